// File: rtl/fibo_arbiter.sv
// Round-robin scheduler that shares one Fibonacci calculator among NREQ requesters.
// One job at a time: launch, wait for a DONE rise or the watchdog, then acknowledge the requester.
module fibo_arbiter #(
    parameter int SIZE    = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] req_count,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [SIZE-1:0]      result,
    output logic                 err,
    output logic                 busy,
    output logic                 calc_start,
    output logic [SIZE-1:0]      calc_count,
    input  logic                 calc_done,
    input  logic [SIZE-1:0]      calc_data
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_REPLY  = 2'd3;

    logic [1:0]      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   timer;
    logic            done_q;

    logic            any_req;
    logic [IW-1:0]   pick;
    logic [SIZE-1:0] pick_count;
    logic [IW-1:0]   ptr_next;
    logic            done_rise;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        any_req    = 1'b0;
        pick       = '0;
        pick_count = '0;
        // First set request at or above the pointer, wrapping around.
        for (int i = 0; i < NREQ; i++) begin
            if (!any_req && req[IW'((int'(ptr) + i) % NREQ)]) begin
                any_req = 1'b1;
                pick    = IW'((int'(ptr) + i) % NREQ);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) pick_count = req_count[i*SIZE +: SIZE];
        end
    end

    assign ptr_next  = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    // A DONE level left over from an earlier job never counts; only a fresh rise does.
    assign done_rise = calc_done && !done_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            idx        <= '0;
            timer      <= '0;
            done_q     <= 1'b0;
            gnt        <= '0;
            ack        <= '0;
            result     <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            calc_start <= 1'b0;
            calc_count <= '0;
        end else begin
            done_q <= calc_done;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state      <= S_LAUNCH;
                        idx        <= pick;
                        gnt        <= onehot(pick);
                        calc_start <= 1'b1;
                        calc_count <= pick_count;
                        busy       <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state      <= S_WAIT;
                    calc_start <= 1'b0;
                    timer      <= '0;
                end
                S_WAIT: begin
                    if (done_rise) begin
                        state  <= S_REPLY;
                        gnt    <= '0;
                        ack    <= onehot(idx);
                        result <= calc_data;
                        err    <= 1'b0;
                        ptr    <= ptr_next;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state  <= S_REPLY;
                        gnt    <= '0;
                        ack    <= onehot(idx);
                        result <= '0;
                        err    <= 1'b1;
                        ptr    <= ptr_next;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_REPLY: begin
                    state  <= S_IDLE;
                    ack    <= '0;
                    result <= '0;
                    err    <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fibo_arbiter.md
# fibo_arbiter

Round-robin scheduler sharing one Fibonacci calculator among NREQ requesters. It accepts per-requester requests and counts, launches one calculator job at a time, and waits for the calculator's completion. It returns the result to the granted requester with a one-cycle acknowledge. A watchdog aborts jobs whose completion never arrives. It sits between client logic and the START/COUNT/DONE/DATA ports of the calculator top level.

## Interface
- SIZE, 4: data and count width, matching the calculator.
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 64: maximum WAIT cycles before abort, ≥ 2.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  request level per requester.
- REQ_COUNT  in  NREQ*SIZE  packed counts; requester i uses bits [i*SIZE +: SIZE].
- GNT  out  NREQ  one-hot; requester being served.
- ACK  out  NREQ  one-cycle pulse to the served requester; result valid.
- RESULT  out  SIZE  result data, valid while ACK ≠ 0.
- ERR  out  1  timeout flag, valid while ACK ≠ 0.
- BUSY  out  1  high when state ≠ IDLE.
- CALC_START  out  1  one-cycle start pulse to the calculator.
- CALC_COUNT  out  SIZE  count to the calculator; holds the last latched value.
- CALC_DONE  in  1  calculator done level.
- CALC_DATA  in  SIZE  calculator result.

## Operation
- Reset (RST=0, asynchronous) clears the following:
  - state=IDLE, round-robin pointer=0, timer=0, done_q=0.
  - All outputs=0.
  - Reset mid-job aborts the job; no ACK is issued. The calculator is not reset by this block.
- done_q registers CALC_DONE every cycle. Completion is recognised only on a rise: CALC_DONE=1 and done_q=0.
- States:
  - IDLE: if any REQ bit is set, pick the first set bit searching upward from the pointer, with wrap-around. Latch its index and its REQ_COUNT slice, then go to LAUNCH. If no REQ bit is set, stay in IDLE.
  - LAUNCH (1 cycle): GNT[idx]=1, CALC_START=1, CALC_COUNT=latched count, timer←0. Go to WAIT.
  - WAIT: GNT[idx]=1, CALC_START=0, timer increments each cycle.
    - On a completion rise: capture CALC_DATA into RESULT, ERR←0, go to REPLY.
    - Else if timer=TIMEOUT-1: RESULT←0, ERR←1, go to REPLY.
    - If the rise and the timeout occur in the same cycle, the rise wins.
  - REPLY (1 cycle): ACK[idx]=1, GNT=0, RESULT and ERR valid, pointer←(idx+1) mod NREQ. Go to IDLE.
- ACK and RESULT/ERR return to 0 in the cycle after REPLY. CALC_COUNT holds its value.
- REQ and REQ_COUNT changes after the grant edge are ignored.
- A requester that drops REQ mid-job still receives its ACK.
- REQ is sampled only in IDLE. REQ still high in the cycle after ACK counts as a new request, which is fair because the pointer has advanced.
- CALC_DONE already high at launch (stale from the previous job) is never accepted. A low-then-high transition is required.
- All outputs come from registers; there is no combinational path from inputs to outputs.

## Timing
- REQ seen in IDLE at edge k: GNT and CALC_START are high in cycle k+1 (LAUNCH). WAIT starts at cycle k+2.
- Completion rise sampled at edge d: ACK/RESULT are high in cycle d+1. IDLE resumes at d+2.
- Timeout: ACK with ERR=1 appears in the cycle after exactly TIMEOUT WAIT cycles.
- Minimum job turnaround: 4 cycles (IDLE, LAUNCH, 1 WAIT, REPLY).
- The next grant can occur 1 cycle after REPLY.

## Test plan
- Reset: assert RST=0 asynchronously during WAIT. All outputs go 0 before the next edge. After release, state is IDLE, no ACK, pointer=0.
- Single job: REQ=0100, slice 2=6. The model raises DONE with DATA=8 ten cycles after START.
  - GNT=0100 and a single CALC_START pulse appear next cycle, with CALC_COUNT=6.
  - ACK=0100 for one cycle, with RESULT=8 and ERR=0.
  - Changing slice 2 to 3 after the grant leaves CALC_COUNT=6.
- Round-robin: all REQ held high, pointer=0, model latency 3 cycles. Grant order is 0,1,2,3,0. Each ACK is a single pulse, and GNT is never multi-hot.
- Timeout: TIMEOUT=16, model never raises DONE. ACK pulses with ERR=1 and RESULT=0 exactly 16 WAIT cycles after WAIT entry. The next request is served normally.
- Stale DONE: CALC_DONE stays high from the previous job until 2 cycles after START, then rises 5 cycles later with DATA=13. There is no premature ACK, and ACK carries RESULT=13.
- Simultaneous: the rise arrives in the cycle where timer=TIMEOUT-1. The result is ERR=0 with the captured data.
